// File: rtl/axi_slave_mux_rn.sv
// AXI read-path 1:N slave mux with address decode and DECERR responder.
// Exactly one burst in flight; unmapped reads are answered locally.
module axi_slave_mux_rn #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
        {32'h0FFF_FFFF, 32'h0FFF_FFFF}
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ID_WIDTH-1:0]            m_ARID,
    input  logic [ADDR_WIDTH-1:0]          m_ARADDR,
    input  logic [7:0]                     m_ARLEN,
    input  logic                           m_ARVALID,
    output logic                           m_ARREADY,
    output logic [ID_WIDTH-1:0]            m_RID,
    output logic [DATA_WIDTH-1:0]          m_RDATA,
    output logic [1:0]                     m_RRESP,
    output logic                           m_RLAST,
    output logic [USER_WIDTH-1:0]          m_RUSER,
    output logic                           m_RVALID,
    input  logic                           m_RREADY,
    output logic [ID_WIDTH-1:0]            s_ARID,
    output logic [ADDR_WIDTH-1:0]          s_ARADDR,
    output logic [7:0]                     s_ARLEN,
    output logic [NUM_SLAVES-1:0]          s_ARVALID,
    input  logic [NUM_SLAVES-1:0]          s_ARREADY,
    input  logic [NUM_SLAVES*ID_WIDTH-1:0] s_RID,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_RDATA,
    input  logic [NUM_SLAVES*2-1:0]        s_RRESP,
    input  logic [NUM_SLAVES-1:0]          s_RLAST,
    input  logic [NUM_SLAVES*USER_WIDTH-1:0] s_RUSER,
    input  logic [NUM_SLAVES-1:0]          s_RVALID,
    output logic [NUM_SLAVES-1:0]          s_RREADY,
    output logic                           busy,
    output logic [15:0]                    decerr_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE  = 2'd1,
        DECERR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [ID_WIDTH-1:0] arid_q, arid_d;
    logic [7:0]          arlen_q, arlen_d;
    logic [8:0]          beat_q, beat_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                  hit;
    logic [1:0]            hit_idx;
    logic                  ar_rdy;
    logic [NUM_SLAVES-1:0] arv;
    logic [NUM_SLAVES-1:0] rrdy;
    logic                  r_valid;
    logic                  r_last;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic [USER_WIDTH-1:0] r_user;

    logic                  sl_valid;
    logic                  sl_last;
    logic [ID_WIDTH-1:0]   sl_id;
    logic [DATA_WIDTH-1:0] sl_data;
    logic [1:0]            sl_resp;
    logic [USER_WIDTH-1:0] sl_user;

    // Descending scan so the lowest matching index is the last to win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_ARADDR & ~SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    always_comb begin
        sl_valid = 1'b0;
        sl_last  = 1'b0;
        sl_id    = '0;
        sl_data  = '0;
        sl_resp  = '0;
        sl_user  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == 2'(i)) begin
                sl_valid = s_RVALID[i];
                sl_last  = s_RLAST[i];
                sl_id    = s_RID[i*ID_WIDTH +: ID_WIDTH];
                sl_data  = s_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sl_resp  = s_RRESP[i*2 +: 2];
                sl_user  = s_RUSER[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        arid_d  = arid_q;
        arlen_d = arlen_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        ar_rdy  = 1'b0;
        arv     = '0;
        rrdy    = '0;
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_id    = '0;
        r_data  = '0;
        r_resp  = '0;
        r_user  = '0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    for (int i = 0; i < NUM_SLAVES; i++) begin
                        if (hit_idx == 2'(i)) begin
                            arv[i] = m_ARVALID;
                            ar_rdy = s_ARREADY[i];
                        end
                    end
                end else begin
                    ar_rdy = 1'b1;
                end
                if (m_ARVALID && ar_rdy) begin
                    sel_d   = hit_idx;
                    arid_d  = m_ARID;
                    arlen_d = m_ARLEN;
                    beat_d  = '0;
                    if (hit) begin
                        state_d = ROUTE;
                    end else begin
                        state_d = DECERR;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
            end
            ROUTE: begin
                r_valid = sl_valid;
                r_last  = sl_last;
                r_id    = sl_id;
                r_data  = sl_data;
                r_resp  = sl_resp;
                r_user  = sl_user;
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (sel_q == 2'(i)) begin
                        rrdy[i] = m_RREADY;
                    end
                end
                if (sl_valid && m_RREADY && sl_last) begin
                    state_d = IDLE;
                end
            end
            DECERR: begin
                r_valid = 1'b1;
                r_resp  = 2'b11;
                r_id    = arid_q;
                r_last  = (beat_q == {1'b0, arlen_q});
                if (m_RREADY) begin
                    if (r_last) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            arid_q  <= '0;
            arlen_q <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            arid_q  <= arid_d;
            arlen_q <= arlen_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake strobes are masked while reset is held, even between edges.
    assign m_ARREADY  = ARESETn & ar_rdy;
    assign s_ARVALID  = {NUM_SLAVES{ARESETn}} & arv;
    assign s_RREADY   = {NUM_SLAVES{ARESETn}} & rrdy;
    assign m_RVALID   = ARESETn & r_valid;
    assign m_RLAST    = r_last;
    assign m_RID      = r_id;
    assign m_RDATA    = r_data;
    assign m_RRESP    = r_resp;
    assign m_RUSER    = r_user;
    assign s_ARID     = m_ARID;
    assign s_ARADDR   = m_ARADDR;
    assign s_ARLEN    = m_ARLEN;
    assign busy       = (state_q != IDLE);
    assign decerr_cnt = cnt_q;

endmodule

// File: tb/tb_axi_slave_mux_rn.sv
// Bench for axi_slave_mux_rn: random AR traffic, two modelled slaves,
// expected R beats queued at issue and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_axi_slave_mux_rn;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam int NS = 2;
    localparam logic [NS*AW-1:0] BASE = {32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK = {32'h0FFF_FFFF, 32'h0FFF_FFFF};

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic [IW-1:0] m_ARID = '0;
    logic [AW-1:0] m_ARADDR = '0;
    logic [7:0] m_ARLEN = '0;
    logic m_ARVALID = 1'b0;
    logic m_ARREADY;
    logic [IW-1:0] m_RID;
    logic [DW-1:0] m_RDATA;
    logic [1:0] m_RRESP;
    logic m_RLAST;
    logic [UW-1:0] m_RUSER;
    logic m_RVALID;
    logic m_RREADY = 1'b0;
    logic [IW-1:0] s_ARID;
    logic [AW-1:0] s_ARADDR;
    logic [7:0] s_ARLEN;
    logic [NS-1:0] s_ARVALID;
    logic [NS-1:0] s_ARREADY = '0;
    logic [NS*IW-1:0] s_RID = '0;
    logic [NS*DW-1:0] s_RDATA = '0;
    logic [NS*2-1:0] s_RRESP = '0;
    logic [NS-1:0] s_RLAST = '0;
    logic [NS*UW-1:0] s_RUSER = '0;
    logic [NS-1:0] s_RVALID = '0;
    logic [NS-1:0] s_RREADY;
    logic busy;
    logic [15:0] decerr_cnt;

    axi_slave_mux_rn #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
        .USER_WIDTH(UW), .NUM_SLAVES(NS),
        .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP),
        .m_RLAST(m_RLAST), .m_RUSER(m_RUSER), .m_RVALID(m_RVALID),
        .m_RREADY(m_RREADY),
        .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
        .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
        .s_RLAST(s_RLAST), .s_RUSER(s_RUSER), .s_RVALID(s_RVALID),
        .s_RREADY(s_RREADY),
        .busy(busy), .decerr_cnt(decerr_cnt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [UW-1:0] user;
        int            tgt;
    } beat_t;

    beat_t exp_q[$];
    beat_t pend0[$];
    beat_t pend1[$];
    beat_t resp0[$];
    beat_t resp1[$];
    bit pop0, pop1, arhs0, arhs1;
    bit junk0 = 1'b0;
    bit expect_idle = 1'b0;
    logic [15:0] exp_decerr = '0;
    int n_checks = 0;
    int n_fail = 0;

    function automatic void chk(input string nm,
                                input logic [159:0] act,
                                input logic [159:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    // Memory map as address regions: 0x0xxx_xxxx slave0, 0x1xxx_xxxx slave1.
    function automatic int model_tgt(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 0;
        if (a[31:28] == 4'h1) return 1;
        return -1;
    endfunction

    function automatic void put_slv(input int i, input bit v, input beat_t b);
        s_RVALID[i] = v;
        s_RID[i*IW +: IW] = b.id;
        s_RDATA[i*DW +: DW] = b.data;
        s_RRESP[i*2 +: 2] = b.resp;
        s_RLAST[i] = b.last;
        s_RUSER[i*UW +: UW] = b.user;
    endfunction

    // Slave models and random back-pressure, updated just after each edge.
    always @(posedge ACLK) begin
        beat_t b;
        beat_t junk;
        beat_t nil;
        #1;
        if (pop0 && resp0.size() > 0) void'(resp0.pop_front());
        if (pop1 && resp1.size() > 0) void'(resp1.pop_front());
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (arhs0) begin
            while (pend0.size() > 0) begin
                b = pend0.pop_front();
                resp0.push_back(b);
                if (b.last) break;
            end
        end
        if (arhs1) begin
            while (pend1.size() > 0) begin
                b = pend1.pop_front();
                resp1.push_back(b);
                if (b.last) break;
            end
        end
        arhs0 = 1'b0;
        arhs1 = 1'b0;
        nil.id = '0; nil.data = '0; nil.resp = '0;
        nil.last = 1'b0; nil.user = '0; nil.tgt = 0;
        junk.id = 4'hF; junk.data = {4{32'hDEAD_BEEF}}; junk.resp = 2'b01;
        junk.last = 1'b1; junk.user = 1'b1; junk.tgt = 0;
        if (resp0.size() > 0 && $urandom_range(0, 3) != 0)
            put_slv(0, 1'b1, resp0[0]);
        else if (junk0 && resp0.size() == 0)
            put_slv(0, 1'b1, junk);
        else
            put_slv(0, 1'b0, nil);
        if (resp1.size() > 0 && $urandom_range(0, 3) != 0)
            put_slv(1, 1'b1, resp1[0]);
        else
            put_slv(1, 1'b0, nil);
        s_ARREADY = 2'($urandom);
        m_RREADY = ($urandom_range(0, 3) != 0);
    end

    // Monitor: all observation happens mid-cycle.
    always @(negedge ACLK) begin
        int t;
        logic [1:0] esv;
        logic [1:0] err;
        logic eary;
        beat_t h;
        if (!ARESETn) begin
            chk("rst_arready", m_ARREADY, 1'b0);
            chk("rst_rvalid", m_RVALID, 1'b0);
            chk("rst_s_arvalid", s_ARVALID, 2'b00);
            chk("rst_s_rready", s_RREADY, 2'b00);
        end else begin
            if (expect_idle) begin
                chk("idle_after_rlast", busy, 1'b0);
                expect_idle = 1'b0;
            end
            chk("ar_passthru", {s_ARID, s_ARADDR, s_ARLEN},
                {m_ARID, m_ARADDR, m_ARLEN});
            if (!busy) begin
                t = model_tgt(m_ARADDR);
                esv = 2'b00;
                eary = 1'b1;
                if (t >= 0) begin
                    eary = s_ARREADY[t];
                    if (m_ARVALID) esv = 2'b01 << t;
                end
                chk("idle_arready", m_ARREADY, eary);
                chk("idle_s_arvalid", s_ARVALID, esv);
                chk("idle_s_rready", s_RREADY, 2'b00);
                chk("idle_r_zero",
                    {m_RVALID, m_RLAST, m_RID, m_RRESP, m_RUSER, m_RDATA}, '0);
            end else begin
                chk("busy_arready", m_ARREADY, 1'b0);
                chk("busy_s_arvalid", s_ARVALID, 2'b00);
                err = 2'b00;
                if (exp_q.size() > 0) begin
                    h = exp_q[0];
                    if (h.tgt >= 0 && m_RREADY) err = 2'b01 << h.tgt;
                    if (h.tgt < 0) chk("decerr_rvalid", m_RVALID, 1'b1);
                end
                chk("busy_s_rready", s_RREADY, err);
            end
            if (m_RVALID && m_RREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    h = exp_q.pop_front();
                    chk("r_beat", {m_RID, m_RRESP, m_RLAST, m_RUSER, m_RDATA},
                        {h.id, h.resp, h.last, h.user, h.data});
                    if (h.last) expect_idle = 1'b1;
                end
            end
            if (s_ARVALID[0] && s_ARREADY[0]) arhs0 = 1'b1;
            if (s_ARVALID[1] && s_ARREADY[1]) arhs1 = 1'b1;
            if (s_RVALID[0] && s_RREADY[0]) pop0 = 1'b1;
            if (s_RVALID[1] && s_RREADY[1]) pop1 = 1'b1;
        end
    end

    task automatic issue_ar(input logic [IW-1:0] id,
                            input logic [31:0] addr,
                            input logic [7:0] len);
        int t;
        int c;
        beat_t b;
        t = model_tgt(addr);
        for (int n = 0; n <= int'(len); n++) begin
            b.id = id;
            b.last = (n == int'(len));
            b.tgt = t;
            if (t < 0) begin
                b.data = '0; b.resp = 2'b11; b.user = '0;
            end else begin
                b.data = {$urandom, $urandom, $urandom, $urandom};
                b.resp = 2'($urandom_range(0, 1));
                b.user = 1'($urandom);
            end
            exp_q.push_back(b);
            if (t == 0) pend0.push_back(b);
            if (t == 1) pend1.push_back(b);
        end
        if (t < 0 && exp_decerr != 16'hFFFF) exp_decerr++;
        @(posedge ACLK); #1;
        m_ARID = id; m_ARADDR = addr; m_ARLEN = len; m_ARVALID = 1'b1;
        c = 0;
        forever begin
            @(negedge ACLK);
            if (m_ARREADY) break;
            c++;
            if (c > 3000) break;
        end
        chk("ar_accept_in_time", c <= 3000, 1'b1);
        @(posedge ACLK); #1;
        m_ARVALID = 1'b0;
        m_ARADDR = $urandom;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        do begin
            @(negedge ACLK);
            c++;
        end while ((exp_q.size() != 0 || busy) && c < 20000);
        chk("drain_in_time", c < 20000, 1'b1);
        chk("decerr_cnt", decerr_cnt, exp_decerr);
    endtask

    task automatic do_reset();
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        m_ARVALID = 1'b0;
        exp_q.delete(); pend0.delete(); pend1.delete();
        resp0.delete(); resp1.delete();
        pop0 = 0; pop1 = 0; arhs0 = 0; arhs1 = 0;
        expect_idle = 1'b0;
        exp_decerr = '0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("post_rst_rvalid", m_RVALID, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_decerr_cnt", decerr_cnt, 16'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int r;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("reset_busy", busy, 1'b0);
        chk("reset_decerr_cnt", decerr_cnt, 16'h0);
        chk("reset_rvalid", m_RVALID, 1'b0);

        issue_ar(4'd2, 32'h1000_0040, 8'd3);
        wait_idle();
        issue_ar(4'd5, 32'h8000_0000, 8'd2);
        wait_idle();

        junk0 = 1'b1;
        issue_ar(4'd1, 32'h1000_0100, 8'd7);
        issue_ar(4'd3, 32'h1FFF_0000, 8'd0);
        issue_ar(4'd4, 32'hC000_0000, 8'd1);
        wait_idle();
        junk0 = 1'b0;

        issue_ar(4'd7, 32'hF000_0000, 8'd0);
        issue_ar(4'd8, 32'h9000_0000, 8'd255);
        issue_ar(4'd9, 32'h0000_1000, 8'd255);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            a = $urandom;
            a[31:28] = (r < 2) ? 4'h0 : (r < 4) ? 4'h1 : 4'(r + 6);
            issue_ar(4'($urandom), a, 8'($urandom_range(0, 15)));
        end
        wait_idle();

        issue_ar(4'd5, 32'hA000_0000, 8'd30);
        repeat (6) @(posedge ACLK);
        do_reset();
        issue_ar(4'd6, 32'h0000_2000, 8'd4);
        issue_ar(4'd11, 32'hB000_0000, 8'd3);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
